reg_file_param: RTL and testbench

//   Parametrised general-purpose register file for the single-cycle datapath.

---
 rtl/reg_file_param.sv | 89 ++++++++
 tb/tb_reg_file_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one write port,
// self-clearing after reset, optional zero register and write-to-read bypass.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] r1,
  input  logic [ADDR_W-1:0] r2,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic              ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  typedef enum logic {INIT, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              we;

  // Addresses outside the array, or the hardwired zero register, are inert.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !(ZERO_REG != 0 && a == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    unique case (state)
      INIT: begin
        clr_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST) state_nxt = READY;
      end
      READY: state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  assign ready = (state == READY);
  assign we    = wr && !rst && ready && live(rd);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        regs[clr_cnt[IDX_W-1:0]] <= '0;
      else if (we)
        regs[rd[IDX_W-1:0]] <= write_data;
    end
  end

  // Write-first when bypassing; zero register wins over the bypass.
  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (ready && live(a)) begin
      if (BYPASS != 0 && we && rd == a)
        v = write_data;
      else
        v = regs[a[IDX_W-1:0]];
    end
    return v;
  endfunction

  assign out1 = read_val(r1);
  assign out2 = read_val(r2);

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench: default build plus a DEPTH=20, no-zero-reg,
// no-bypass build sharing clock and reset.
module tb_reg_file_param;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr, wr_b;
  logic [AW-1:0] rd, rd_b, r1, r1_b, r2, r2_b;
  logic [DW-1:0] write_data, write_data_b;
  logic [DW-1:0] out1, out2, out1_b, out2_b;
  logic          ready, ready_b;

  always #5 clk = ~clk;

  reg_file_param u_dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd),
    .write_data(write_data), .r1(r1), .r2(r2),
    .out1(out1), .out2(out2), .ready(ready)
  );

  reg_file_param #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(20),
    .ZERO_REG(0), .BYPASS(0)
  ) u_alt (
    .clk(clk), .rst(rst), .wr(wr_b), .rd(rd_b),
    .write_data(write_data_b), .r1(r1_b), .r2(r2_b),
    .out1(out1_b), .out2(out2_b), .ready(ready_b)
  );

  typedef struct {
    string         tag;
    int            src;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   lat_a, lat_b;

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic push(input string tag, input int src,
                      input logic [DW-1:0] exp);
    sb.push_back('{tag, src, exp});
  endtask

  function automatic logic [DW-1:0] obs(input int src);
    case (src)
      0: return out1;
      1: return out2;
      2: return DW'(ready);
      3: return out1_b;
      4: return out2_b;
      5: return DW'(ready_b);
      6: return DW'(lat_a);
      default: return DW'(lat_b);
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.src), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #2;
    drain();
  endtask

  task automatic wait_ready();
    lat_a = 999;
    lat_b = 999;
    for (int e = 1; e <= 64 && (lat_a == 999 || lat_b == 999); e++) begin
      cyc();
      #2;
      if (ready && lat_a == 999) lat_a = e;
      if (ready_b && lat_b == 999) lat_b = e;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end

  initial begin
    wr = 1'b1; rd = 5'd3; write_data = 32'hFF;
    r1 = 5'd3; r2 = 5'd3;
    wr_b = 1'b0; rd_b = '0; write_data_b = '0;
    r1_b = '0; r2_b = '0;

    // reset for two edges
    @(posedge clk);
    @(negedge clk);
    push("rst_ready", 2, 0);
    push("rst_out1", 0, 0);
    push("rst_out2", 1, 0);
    push("rst_ready_b", 5, 0);
    drain();
    cyc();
    rst = 1'b0;

    // clear sequence with writes attempted every INIT cycle
    for (int e = 1; e <= 32; e++) begin
      cyc();
      if (e == 32) wr = 1'b0;
      push($sformatf("init_ready_%0d", e), 2, DW'(e >= 32));
      push($sformatf("init_ready_b_%0d", e), 5, DW'(e >= 20));
      push($sformatf("init_out1_%0d", e), 0, 0);
      push($sformatf("init_out2_%0d", e), 1, 0);
      sample();
    end

    for (int a = 0; a < 32; a++) begin
      cyc();
      r1 = AW'(a);
      r2 = AW'(31 - a);
      push($sformatf("clr_rd1_%0d", a), 0, 0);
      push($sformatf("clr_rd2_%0d", a), 1, 0);
      sample();
    end

    // write / read, zero register
    cyc();
    wr = 1'b1; rd = 5'd5; write_data = 32'hDEADBEEF;
    r1 = 5'd0; r2 = 5'd0;
    cyc();
    wr = 1'b1; rd = 5'd0; write_data = 32'h1234;
    r1 = 5'd5; r2 = 5'd0;
    push("wr5_rd", 0, 32'hDEADBEEF);
    push("zero_byp", 1, 0);
    sample();
    cyc();
    wr = 1'b0;
    push("zero_rd", 1, 0);
    push("wr5_hold", 0, 32'hDEADBEEF);
    sample();

    // bypass vs read-first
    cyc();
    wr = 1'b1; rd = 5'd7; write_data = 32'h11111111;
    wr_b = 1'b1; rd_b = 5'd7; write_data_b = 32'h11;
    cyc();
    write_data = 32'hA5A5A5A5; r1 = 5'd7; r2 = 5'd7;
    write_data_b = 32'h22; r1_b = 5'd7; r2_b = 5'd7;
    push("byp_out1", 0, 32'hA5A5A5A5);
    push("byp_out2", 1, 32'hA5A5A5A5);
    push("rf_old1", 3, 32'h11);
    push("rf_old2", 4, 32'h11);
    sample();
    cyc();
    wr = 1'b0; wr_b = 1'b0;
    push("byp_after1", 0, 32'hA5A5A5A5);
    push("byp_after2", 1, 32'hA5A5A5A5);
    push("rf_new1", 3, 32'h22);
    push("rf_new2", 4, 32'h22);
    sample();

    // out-of-range and ordinary register 0 on the small build
    cyc();
    wr_b = 1'b1; rd_b = 5'd25; write_data_b = 32'h77;
    r1_b = 5'd25; r2_b = 5'd25;
    push("oor_byp", 3, 0);
    sample();
    cyc();
    rd_b = 5'd0; write_data_b = 32'h55;
    push("oor_rd", 3, 0);
    sample();
    cyc();
    rd_b = 5'd19; write_data_b = 32'h99; r1_b = 5'd0;
    push("r0_rd", 3, 32'h55);
    sample();
    cyc();
    wr_b = 1'b0; r1_b = 5'd19;
    push("top_rd", 3, 32'h99);
    push("oor_rd2", 4, 0);
    sample();

    // fill 1..4, reset in READY and again mid-INIT
    for (int i = 1; i <= 4; i++) begin
      cyc();
      wr = 1'b1; rd = AW'(i); write_data = 32'h100 + i;
      wr_b = 1'b1; rd_b = AW'(i); write_data_b = 32'h200 + i;
    end
    cyc();
    wr = 1'b0; wr_b = 1'b0;
    r1 = 5'd4; r2 = 5'd1; r1_b = 5'd3;
    push("fill_r4", 0, 32'h104);
    push("fill_r1", 1, 32'h101);
    push("fill_b_r3", 3, 32'h203);
    sample();
    cyc();
    rst = 1'b1;
    cyc();
    push("rst_drop", 2, 0);
    push("rst_drop_b", 5, 0);
    push("rst_out1", 0, 0);
    sample();
    rst = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    push("relat", 6, 32);
    push("relat_b", 7, 20);
    wait_ready();
    drain();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      r1 = AW'(i); r2 = AW'(i); r1_b = AW'(i); r2_b = AW'(i);
      push($sformatf("post_r1_%0d", i), 0, 0);
      push($sformatf("post_r2_%0d", i), 1, 0);
      push($sformatf("post_b1_%0d", i), 3, 0);
      push($sformatf("post_b2_%0d", i), 4, 0);
      sample();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
